// File: rtl/ad7606_frame_packer.sv
// AD7606 frame packer: snapshots the latest 8-channel sample set and, once per
// send tick, streams it to the UART TX core as a 19-byte frame:
// HEAD0, HEAD1, 16 data bytes (channel 1..8, high byte first), checksum.
module ad7606_frame_packer #(
  parameter int unsigned CLK_FRE  = 50,
  parameter int unsigned SEND_FRE = 2,
  parameter logic [7:0]  HEAD0    = 8'hAA,
  parameter logic [7:0]  HEAD1    = 8'h55
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0][15:0] ad7606_data,
  input  logic             ad7606_done,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             frame_drop
);

  localparam int unsigned PERIOD = (CLK_FRE * 1_000_000) / SEND_FRE;
  localparam int unsigned CW     = $clog2(PERIOD);
  localparam int unsigned IW     = 5;
  localparam logic [IW-1:0] LAST_IDX = IW'(18);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [CW-1:0]    cnt;
  logic             tick;
  logic [7:0][15:0] shadow;
  logic [7:0][15:0] frame_buf;
  logic [7:0]       csum;
  logic [7:0]       sum_c;
  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [7:0]       tx_data_d;
  logic             tx_valid_d, busy_d, drop_d, load_c;

  // Byte presented at a given frame index.
  function automatic logic [7:0] byte_at(input logic [IW-1:0] idx,
                                         input logic [7:0][15:0] fb,
                                         input logic [7:0] cs);
    logic [3:0] off;
    off = 4'(idx - IW'(2));
    if (idx == IW'(0))          return HEAD0;
    else if (idx == IW'(1))     return HEAD1;
    else if (idx == LAST_IDX)   return cs;
    else if (off[0])            return fb[off[3:1]][7:0];
    else                        return fb[off[3:1]][15:8];
  endfunction

  // Free-running send-tick counter.
  assign tick = (cnt == CW'(PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  // Shadow register tracks the most recent coherent sample set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           shadow <= '0;
    else if (ad7606_done) shadow <= ad7606_data;
  end

  // Mod-256 sum of the 16 data bytes held in the shadow.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < 8; i++) begin
      sum_c = sum_c + shadow[i][15:8] + shadow[i][7:0];
    end
  end

  // Frame buffer and checksum are frozen for the whole frame at LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_buf <= '0;
      csum      <= '0;
    end else if (load_c) begin
      frame_buf <= shadow;
      csum      <= sum_c;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data;
    tx_valid_d = tx_valid;
    busy_d     = busy;
    drop_d     = 1'b0;
    load_c     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        if (tick) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        load_c     = 1'b1;
        drop_d     = tick;
        idx_d      = '0;
        tx_data_d  = HEAD0;
        tx_valid_d = 1'b1;
        busy_d     = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        drop_d = tick;
        if (tx_valid && tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
          end else begin
            idx_d     = idx_q + IW'(1);
            tx_data_d = byte_at(idx_d, frame_buf, csum);
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_data    <= tx_data_d;
      tx_valid   <= tx_valid_d;
      busy       <= busy_d;
      frame_drop <= drop_d;
    end
  end

endmodule

// File: tb/tb_ad7606_frame_packer.sv
// Directed bench for ad7606_frame_packer with a 100-cycle send period.
module tb_ad7606_frame_packer;

  typedef logic [7:0] frame_t [19];

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0][15:0] ad7606_data;
  logic             ad7606_done;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             frame_drop;

  int n_cmp = 0;
  int n_err = 0;
  int edges = 0;

  ad7606_frame_packer #(.CLK_FRE(1), .SEND_FRE(10000)) dut (
    .clk(clk), .rst_n(rst_n), .ad7606_data(ad7606_data),
    .ad7606_done(ad7606_done), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (edges < target) step();
  endtask

  function automatic frame_t mk(input logic [7:0][15:0] d, input logic [7:0] cs);
    frame_t f;
    f[0] = 8'hAA;
    f[1] = 8'h55;
    for (int c = 0; c < 8; c++) begin
      f[2 + 2*c] = d[c][15:8];
      f[3 + 2*c] = d[c][7:0];
    end
    f[18] = cs;
    return f;
  endfunction

  // Receive one frame, optionally toggling tx_ready 1,0,0,1 and injecting a
  // done pulse while byte index inj_k is being offered.
  task automatic collect(input frame_t exp, input bit toggle, input string tag,
                         input int inj_k, input logic [7:0][15:0] inj,
                         output int nvalid, output int nbusy);
    int  k     = 0;
    int  p     = 0;
    int  guard = 0;
    bit  done_inj = 1'b0;
    nvalid = 0;
    nbusy  = 0;
    while (!tx_valid && guard < 300) begin
      tx_ready = 1'b1;
      step();
      guard++;
    end
    check({tag, "_start"}, 32'(tx_valid), 32'd1);
    while (k < 19 && guard < 600) begin
      ad7606_done = 1'b0;
      if (inj_k >= 0 && !done_inj && k == inj_k) begin
        ad7606_data = inj;
        ad7606_done = 1'b1;
        done_inj    = 1'b1;
      end
      tx_ready = toggle ? ((p % 4) == 0 || (p % 4) == 3) : 1'b1;
      check({tag, "_valid"}, 32'(tx_valid), 32'd1);
      check({tag, "_byte"}, 32'(tx_data), 32'(exp[k]));
      if (busy) nbusy++;
      nvalid++;
      p++;
      if (tx_ready) k++;
      step();
      guard++;
    end
    ad7606_done = 1'b0;
    check({tag, "_count"}, 32'(k), 32'd19);
    check({tag, "_end_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0][15:0] d1, d2, d5, dz;
    frame_t f1, f2, f5, f6;
    int e0, e1, nv, nb, drops, stray;
    logic busy_load;

    d1 = '0;
    d1[0] = 16'h1234;
    for (int n = 1; n <= 8; n++) d2[n-1] = 16'(16'h0101 * n);
    d5 = d2;
    d5[7] = 16'hFFFF;
    dz = '0;
    f1 = mk(d1, 8'h46);
    f2 = mk(d2, 8'h48);
    f5 = mk(d5, 8'h36);
    f6 = mk(dz, 8'h00);

    rst_n = 1'b0;
    tx_ready = 1'b0;
    ad7606_done = 1'b0;
    ad7606_data = '0;

    // Reset state
    #1;
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_drop", 32'(frame_drop), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    e0 = edges;

    // Test 1: ch1=1234, exact latency and busy window
    ad7606_data = d1;
    ad7606_done = 1'b1;
    tx_ready = 1'b1;
    step();
    ad7606_done = 1'b0;
    wait_until(e0 + 99);
    check("t1_busy_before_tick", 32'(busy), 32'd0);
    step();
    busy_load = busy;
    check("t1_load_busy", 32'(busy), 32'd1);
    check("t1_load_valid", 32'(tx_valid), 32'd0);
    step();
    check("t1_first_valid", 32'(tx_valid), 32'd1);
    collect(f1, 1'b0, "t1", -1, d1, nv, nb);
    check("t1_valid_cycles", 32'(nv), 32'd19);
    check("t1_busy_total", 32'(nb + int'(busy_load)), 32'd20);

    // Test 2: channel n = 0101*n
    ad7606_data = d2;
    ad7606_done = 1'b1;
    step();
    ad7606_done = 1'b0;
    wait_until(e0 + 200);
    check("t2_load_busy", 32'(busy), 32'd1);
    collect(f2, 1'b0, "t2", -1, d2, nv, nb);
    check("t2_valid_cycles", 32'(nv), 32'd19);

    // Test 3: tx_ready toggling 1,0,0,1
    collect(f2, 1'b1, "t3", -1, d2, nv, nb);
    check("t3_valid_cycles", 32'(nv), 32'd37);

    // Test 4: stalled sink across a tick
    tx_ready = 1'b0;
    wait_until(e0 + 401);
    drops = 0;
    while (edges < e0 + 551) begin
      check("t4_hold_valid", 32'(tx_valid), 32'd1);
      check("t4_hold_data", 32'(tx_data), 32'hAA);
      if (frame_drop) drops++;
      if (edges == e0 + 500) check("t4_drop_at_tick", 32'(frame_drop), 32'd1);
      step();
    end
    check("t4_drop_count", 32'(drops), 32'd1);
    collect(f2, 1'b0, "t4", -1, d2, nv, nb);
    wait_until(e0 + 599);
    check("t4_idle_before_next", 32'(busy), 32'd0);
    step();
    check("t4_next_frame_busy", 32'(busy), 32'd1);

    // Test 5: done pulse at index 5 only affects the following frame
    collect(f2, 1'b0, "t5_cur", 5, d5, nv, nb);
    collect(f5, 1'b0, "t5_next", -1, d5, nv, nb);

    // Test 6: reset in the middle of a frame
    tx_ready = 1'b1;
    wait_until(e0 + 811);
    check("t6_idx10", 32'(tx_data), 32'h05);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(tx_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_data", 32'(tx_data), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    e1 = edges;
    stray = 0;
    while (edges < e1 + 99) begin
      step();
      if (tx_valid || busy) stray++;
    end
    check("t6_quiet_period", 32'(stray), 32'd0);
    step();
    check("t6_load_busy", 32'(busy), 32'd1);
    check("t6_load_valid", 32'(tx_valid), 32'd0);
    collect(f6, 1'b0, "t6", -1, dz, nv, nb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
